// File: rtl/fir_decim_out_if.sv
// fir_decim_out_if: filter-side input, consumer-side output and status of the FIR output stage
interface fir_decim_out_if #(
  parameter int IN_W  = 18,
  parameter int OUT_W = 8,
  parameter int DEPTH = 4
);
  logic                     clear;
  logic                     in_valid;
  logic [IN_W-1:0]          in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_W-1:0]         out_data;
  logic [$clog2(DEPTH):0]   level;
  logic                     overflow;
  logic                     sat_pulse;
  modport master (
    output clear, in_valid, in_data, out_ready,
    input  out_valid, out_data, level, overflow, sat_pulse
  );
  modport slave (
    input  clear, in_valid, in_data, out_ready,
    output out_valid, out_data, level, overflow, sat_pulse
  );
endinterface

// File: rtl/fir_decim_out.sv
// fir_decim_out: decimate, round/shift/saturate FIR results and buffer them in a show-ahead FIFO
module fir_decim_out #(
  parameter int IN_W  = 18,
  parameter int OUT_W = 8,
  parameter int DECIM = 2,
  parameter int SHIFT = 3,
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  fir_decim_out_if.slave  bus
);
  localparam int PW = DECIM > 1 ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [IN_W:0] RND = SHIFT > 0 ? (IN_W+1)'(1) << (SHIFT > 0 ? SHIFT - 1 : 0) : '0;
  logic [PW-1:0]    r_phase;
  logic             r_stg_v;
  logic             r_stg_sat;
  logic [OUT_W-1:0] r_stg_d;
  logic [OUT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [LW-1:0]    r_level;
  logic             r_ovf;
  logic             r_sat;
  logic [IN_W:0]    w_r;
  logic             w_sat;
  logic             w_keep;
  logic             w_empty;
  logic             w_full;
  logic             w_rd;
  logic             w_wr;
  // one extra bit keeps the rounding add from wrapping
  always_comb begin
    w_r     = ({1'b0, bus.in_data} + RND) >> SHIFT;
    w_sat   = |w_r[IN_W:OUT_W];
    w_keep  = bus.in_valid & (r_phase == '0);
    w_empty = r_level == '0;
    w_full  = r_level == LW'(DEPTH);
    w_rd    = ~w_empty & bus.out_ready;
    w_wr    = r_stg_v & (~w_full | w_rd);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase   <= '0;
      r_stg_v   <= 1'b0;
      r_stg_sat <= 1'b0;
      r_stg_d   <= '0;
      r_wr      <= '0;
      r_rd      <= '0;
      r_level   <= '0;
      r_ovf     <= 1'b0;
      r_sat     <= 1'b0;
    end else if (bus.clear) begin
      r_phase   <= '0;
      r_stg_v   <= 1'b0;
      r_stg_sat <= 1'b0;
      r_stg_d   <= '0;
      r_wr      <= '0;
      r_rd      <= '0;
      r_level   <= '0;
      r_ovf     <= 1'b0;
      r_sat     <= 1'b0;
    end else begin
      if (bus.in_valid) r_phase <= r_phase == PW'(DECIM - 1) ? '0 : r_phase + 1'b1;
      r_stg_v <= w_keep;
      if (w_keep) begin
        r_stg_d   <= w_sat ? '1 : w_r[OUT_W-1:0];
        r_stg_sat <= w_sat;
      end
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (w_rd) r_rd <= r_rd + 1'b1;
      r_level <= r_level + LW'(w_wr) - LW'(w_rd);
      if (r_stg_v & ~w_wr) r_ovf <= 1'b1;
      r_sat <= w_wr & r_stg_sat;
    end
  end
  always_ff @(posedge clk)
    if (w_wr & ~bus.clear) r_mem[r_wr] <= r_stg_d;
  assign bus.out_valid = ~w_empty;
  assign bus.out_data  = w_empty ? '0 : r_mem[r_rd];
  assign bus.level     = r_level;
  assign bus.overflow  = r_ovf;
  assign bus.sat_pulse = r_sat;
endmodule
